// File: rtl/icache_refill.sv
// Instruction-cache refill engine: turns a fetch miss into one AXI4 INCR read
// burst for the whole line and streams each returned beat into the cache arrays.
module icache_refill #(
  parameter int B = 64,
  parameter int b = 3,
  parameter int y = 3,
  parameter int N = 2,
  localparam int WW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          miss_req,
  input  logic [63:0]   miss_addr,
  input  logic [WW-1:0] victim_way,
  output logic          m_axi_arvalid,
  input  logic          m_axi_arready,
  output logic [63:0]   m_axi_araddr,
  output logic [7:0]    m_axi_arlen,
  output logic [2:0]    m_axi_arsize,
  output logic [1:0]    m_axi_arburst,
  input  logic          m_axi_rvalid,
  output logic          m_axi_rready,
  input  logic [63:0]   m_axi_rdata,
  input  logic [1:0]    m_axi_rresp,
  input  logic          m_axi_rlast,
  output logic          fill_we,
  output logic [63:0]   fill_addr,
  output logic [WW-1:0] fill_way,
  output logic [b-1:0]  fill_word,
  output logic [63:0]   fill_data,
  output logic          fill_done,
  output logic          fill_err,
  output logic          busy
);

  localparam int BEATS = B / 8;
  localparam logic [b-1:0] LAST_BEAT = b'(BEATS - 1);
  localparam logic [63:0] LINE_MASK = ~((64'd1 << (b + y)) - 64'd1);

  typedef enum logic [1:0] {IDLE, AR, DATA, DONE} state_t;

  state_t        state_q, state_d;
  logic          miss_req_q;
  logic [63:0]   line_addr_q, line_addr_d;
  logic [WW-1:0] way_q, way_d;
  logic [b-1:0]  cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          start;

  // Only a fresh miss starts a refill; a level held high must not retrigger.
  assign start = miss_req & ~miss_req_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      miss_req_q  <= 1'b0;
      line_addr_q <= '0;
      way_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_req_q  <= miss_req;
      line_addr_q <= line_addr_d;
      way_q       <= way_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    line_addr_d   = line_addr_q;
    way_d         = way_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    fill_we       = 1'b0;
    fill_word     = '0;
    fill_data     = '0;
    fill_done     = 1'b0;
    fill_err      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          line_addr_d = miss_addr & LINE_MASK;
          way_d       = victim_way;
          cnt_d       = '0;
          err_d       = 1'b0;
          state_d     = AR;
        end
      end
      AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) begin
          fill_we   = 1'b1;
          fill_word = cnt_q;
          fill_data = m_axi_rdata;
          cnt_d     = cnt_q + 1'b1;
          if (m_axi_rresp != 2'b00) err_d = 1'b1;
          // A line always ends after BEATS beats or at rlast, whichever first;
          // any disagreement between the two marks the line bad.
          if (cnt_q == LAST_BEAT) begin
            if (!m_axi_rlast) err_d = 1'b1;
            state_d = DONE;
          end else if (m_axi_rlast) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        fill_done = 1'b1;
        fill_err  = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_axi_araddr  = line_addr_q;
  assign m_axi_arlen   = 8'(BEATS - 1);
  assign m_axi_arsize  = 3'd3;
  assign m_axi_arburst = 2'b01;
  assign fill_addr     = line_addr_q;
  assign fill_way      = way_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_icache_refill.sv
// Randomized bench for icache_refill: a bench-side AXI slave delivers planned
// beats while a transaction-level model predicts every write and completion.
module tb_icache_refill;

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_req;
  logic [63:0] miss_addr;
  logic        victim_way;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [63:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;
  logic        fill_we;
  logic [63:0] fill_addr;
  logic        fill_way;
  logic [2:0]  fill_word;
  logic [63:0] fill_data;
  logic        fill_done;
  logic        fill_err;
  logic        busy;

  always #5 clk = ~clk;

  icache_refill #(.B(64), .b(3), .y(3), .N(2)) dut (
    .clk(clk), .reset(reset), .miss_req(miss_req), .miss_addr(miss_addr),
    .victim_way(victim_way),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .fill_we(fill_we), .fill_addr(fill_addr), .fill_way(fill_way),
    .fill_word(fill_word), .fill_data(fill_data), .fill_done(fill_done),
    .fill_err(fill_err), .busy(busy)
  );

  typedef struct {
    logic [63:0] addr;
    logic        way;
    int          word;
    logic [63:0] data;
  } wr_t;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  wr_t         w;
  logic [63:0] exp_line;
  logic [63:0] pin_line = '0;
  logic        exp_way;
  logic        exp_err;
  bit          ar_pending = 0;
  bit          abort_mode = 0;
  int          cap_cyc = 0;
  int          exp_lat = -1;
  int          ar_count = 0;
  int          done_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Compare process: every cycle, DUT outputs against the transaction model.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_axi_arvalid) begin
        chk("ar_expected", 64'(ar_pending), 64'd1);
        chk("araddr", m_axi_araddr, exp_line);
        if (pin_line != 64'd0) chk("araddr_pinned", m_axi_araddr, pin_line);
        chk("arlen", 64'(m_axi_arlen), 64'd7);
        chk("arsize", 64'(m_axi_arsize), 64'd3);
        chk("arburst", 64'(m_axi_arburst), 64'd1);
        if (m_axi_arready) begin
          ar_pending = 0;
          ar_count++;
        end
      end
      if (fill_we || (m_axi_rvalid && m_axi_rready)) begin
        chk("we_vs_handshake", 64'(fill_we), 64'(m_axi_rvalid && m_axi_rready));
        if (fill_we) begin
          chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("fill_addr", fill_addr, w.addr);
            chk("fill_way", 64'(fill_way), 64'(w.way));
            chk("fill_word", 64'(fill_word), 64'(w.word));
            chk("fill_data", fill_data, w.data);
          end
        end
      end
      if (fill_done) begin
        done_count++;
        chk("done_allowed", 64'(abort_mode), 64'd0);
        chk("fill_err", 64'(fill_err), 64'(exp_err));
        chk("writes_left_at_done", 64'(exp_q.size()), 64'd0);
        chk("rready_in_done", 64'(m_axi_rready), 64'd0);
        chk("busy_in_done", 64'(busy), 64'd1);
        if (exp_lat >= 0) chk("done_latency", 64'(cyc - cap_cyc), 64'(exp_lat));
      end
    end
  end

  // One refill: the slave delivers n beats (ending at rlast or after 8),
  // the model expects exactly those writes and the error flag they imply.
  task automatic run_txn(input logic [63:0] addr, input logic wy, input int ar_delay,
                         input int gap, input int bad_beat, input int last_beat,
                         input int rst_beat, input int hold_extra, input int lat,
                         input bit idx_data);
    logic [63:0] data [8];
    int n, beat, ar_wait, ar0;
    bit phase_data, hs_ar, hs_r, done, aborted;
    n = (last_beat < 8) ? last_beat + 1 : 8;
    for (int i = 0; i < 8; i++) data[i] = idx_data ? 64'(i) : {$urandom, $urandom};
    exp_line   = addr & ~64'h3f;
    exp_way    = wy;
    exp_err    = (bad_beat >= 0 && bad_beat < n) || (last_beat != 7);
    exp_lat    = lat;
    abort_mode = (rst_beat >= 0);
    for (int i = 0; i < n; i++)
      if (rst_beat < 0 || i < rst_beat) exp_q.push_back('{exp_line, wy, i, data[i]});
    ar0        = ar_count;
    ar_pending = 1;
    miss_addr  = addr;
    victim_way = wy;
    miss_req   = 1'b1;
    cap_cyc    = cyc;
    beat = 0; ar_wait = 0; phase_data = 0; done = 0; aborted = 0;
    for (int t = 0; t < 300 && !done; t++) begin
      m_axi_arready = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_rlast   = 1'b0;
      m_axi_rresp   = 2'b00;
      m_axi_rdata   = {$urandom, $urandom};
      if (m_axi_arvalid) begin
        m_axi_arready = (ar_wait >= ar_delay);
        ar_wait++;
      end
      if (phase_data && beat < n) begin
        m_axi_rvalid = (gap == 0) || (gap == 1 && t[0] == 1'b0) ||
                       (gap == 2 && $urandom_range(99) >= 30);
        m_axi_rdata  = data[beat];
        m_axi_rresp  = (beat == bad_beat) ? 2'b10 : 2'b00;
        m_axi_rlast  = (beat == last_beat);
        if (beat == rst_beat && m_axi_rvalid) begin
          reset    = 1'b1;
          miss_req = 1'b0;
        end
      end
      @(negedge clk);
      hs_ar = m_axi_arvalid && m_axi_arready;
      hs_r  = m_axi_rvalid && m_axi_rready;
      if (fill_done) done = 1;
      @(posedge clk);
      #1;
      if (hs_ar) phase_data = 1;
      if (hs_r) beat++;
      if (reset) begin
        aborted = 1;
        done    = 1;
      end
    end
    chk("txn_completed", 64'(done), 64'd1);
    m_axi_arready = 1'b0;
    m_axi_rlast   = 1'b0;
    m_axi_rresp   = 2'b00;
    if (aborted) begin
      reset        = 1'b0;
      m_axi_rvalid = 1'b1;
      @(negedge clk);
      chk("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
      chk("rst_rready", 64'(m_axi_rready), 64'd0);
      chk("rst_fill_we", 64'(fill_we), 64'd0);
      chk("rst_fill_done", 64'(fill_done), 64'd0);
      chk("rst_fill_err", 64'(fill_err), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_fill_addr", fill_addr, 64'd0);
      chk("writes_before_reset", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      abort_mode = 0;
      ar_pending = 0;
      @(posedge clk);
      #1;
      m_axi_rvalid = 1'b0;
    end else begin
      m_axi_rvalid = 1'b0;
      @(negedge clk);
      chk("idle_after_done", 64'(busy), 64'd0);
      chk("done_single_pulse", 64'(fill_done), 64'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < hold_extra; i++) begin
        @(posedge clk);
        #1;
      end
      chk("ar_bursts_per_miss", 64'(ar_count - ar0), 64'd1);
    end
    miss_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    $display("txn addr=%h way=%0d beats=%0d exp_err=%0d abort=%0d checks=%0d errors=%0d",
             addr, wy, n, exp_err, aborted, checks, errors);
  endtask

  initial begin
    reset = 1'b1; miss_req = 1'b0; miss_addr = '0; victim_way = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_arvalid", 64'(m_axi_arvalid), 64'd0);
    chk("reset_rready", 64'(m_axi_rready), 64'd0);
    chk("reset_fill_we", 64'(fill_we), 64'd0);
    chk("reset_fill_done", 64'(fill_done), 64'd0);
    chk("reset_fill_err", 64'(fill_err), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_araddr", m_axi_araddr, 64'd0);
    chk("reset_fill_way", 64'(fill_way), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic fill with literal address and 10-cycle completion latency.
    pin_line = 64'h8000_1200;
    run_txn(64'h8000_1234, 1'b1, 0, 0, -1, 7, -1, 0, 10, 1'b1);
    pin_line = '0;
    // Backpressure on AR and alternate-cycle R gaps.
    run_txn(64'h0000_0000_1234_5678, 1'b0, 3, 1, -1, 7, -1, 0, -1, 1'b0);
    // Error response on beat 4: all beats written, error flagged.
    run_txn(64'h0000_7fff_0000_0040, 1'b1, 0, 0, 4, 7, -1, 0, 10, 1'b0);
    // Early rlast on beat 5: six writes, done at capture+8.
    run_txn(64'hdead_beef_0000_10c8, 1'b0, 0, 0, -1, 5, -1, 0, 8, 1'b0);
    // rlast missing on the final beat.
    run_txn(64'h0000_0000_0000_0ff8, 1'b1, 0, 0, -1, 8, -1, 0, 10, 1'b0);
    // miss_req held for 40+ cycles, then a second rising edge.
    run_txn(64'h0000_1111_2222_3338, 1'b0, 1, 0, -1, 7, -1, 40, -1, 1'b0);
    run_txn(64'h0000_1111_2222_3378, 1'b1, 0, 0, -1, 7, -1, 0, 10, 1'b0);
    // Reset during beat 3, then a normal refill.
    run_txn(64'h0000_0000_abcd_0010, 1'b1, 0, 0, -1, 7, 3, 0, -1, 1'b0);
    run_txn(64'h0000_0000_abcd_0050, 1'b0, 0, 0, -1, 7, -1, 0, 10, 1'b0);

    for (int k = 0; k < 25; k++) begin
      run_txn({$urandom, $urandom}, 1'($urandom_range(1)), int'($urandom_range(3)), 2,
              ($urandom_range(3) == 0) ? int'($urandom_range(7)) : -1,
              ($urandom_range(4) == 0) ? int'($urandom_range(8)) : 7,
              -1, 0, -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
